reg_control_unit: RTL and testbench
===================================

Name: reg_control_unit

Overview:
- Control-side sequencer for the 4-bit X/Y/Z register file.
- Accepts one instruction per start/done handshake and expands it into multi-cycle 3-bit register opcodes: HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100.
- Also drives the ULA operation select and the X load-source select.
- Sits between the instruction/keypad front end and the datapath registers.

Parameters:
- AMT_W, 2, width of shift amount field; max shift count is 2**AMT_W-1.
- DONE_HOLD, 0, extra HOLD cycles inserted before done; 0..3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  instruction request; sampled only in IDLE.
- op  input  3  instruction opcode; captured with start.
- amt  input  AMT_W  shift count for SHR/SHL; captured with start.
- tx  output  3  X register opcode.
- ty  output  3  Y register opcode.
- tz  output  3  Z register opcode.
- ula_op  output  2  ULA select: 00 add, 01 sub, 10 pass X, 11 pass Y.
- x_src  output  1  X load source: 0 = external in, 1 = Z.
- busy  output  1  high from cycle after accepted start until done cycle inclusive.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state): state=IDLE; tx=ty=tz=000; ula_op=00; x_src=0; busy=0; done=0; internal count=0.
- All outputs are registered. A datapath register acts on the edge after its opcode appears.
- FSM states and transitions:
  - IDLE: start=1 -> DECODE, latch op/amt, busy=1. Otherwise stay in IDLE.
  - DECODE: all opcodes HOLD.
    - NOP, or SHR/SHL with amt=0 -> WAIT.
    - Any other op -> EXEC, with count = amt for shifts, else 1.
  - EXEC: drive the op's opcodes for one cycle; count decrements each cycle; leave when count reaches 0 -> WAIT.
  - WAIT: all HOLD for DONE_HOLD cycles (0 means pass straight through) -> DONE.
  - DONE: done=1, busy=1, all HOLD -> IDLE. busy=0 and done=0 in IDLE.
- EXEC output per opcode (unlisted fields HOLD, ula_op=00, x_src=0):
  - 000 NOP: no EXEC cycle.
  - 001 LDX: tx=LOAD, x_src=0.
  - 010 ADD: ula_op=00, tz=LOAD.
  - 011 SUB: ula_op=01, tz=LOAD.
  - 100 SHR: tx=SHIFTR for amt consecutive cycles.
  - 101 SHL: tx=SHIFTL for amt consecutive cycles.
  - 110 CLR: tx=ty=tz=RESET.
  - 111 MOVZX: tx=LOAD, x_src=1.
- Latency:
  - start at edge n -> EXEC outputs valid after edge n+2.
  - done after edge n+2+E+DONE_HOLD, where E = number of EXEC cycles (0 for NOP and amt=0).
- Boundary conditions:
  - start while busy: ignored, no queuing; op/amt changes while busy are ignored.
  - start asserted continuously: a new instruction is accepted on the first IDLE cycle after DONE, so the back-to-back issue rate is 3+E+DONE_HOLD cycles.
  - Reset mid-EXEC: outputs return to HOLD immediately (asynchronously); the partially executed shift is not completed.
  - amt at max (3 for AMT_W=2): exactly 3 SHIFT cycles, no wrap.

Optional Feature:
- Macro: REG_CTRL_INSTR_COUNT_EN.
- Defined: adds output instr_count [7:0].
  - Increments in each DONE cycle and wraps 255 -> 0.
  - Cleared by rst.
  - NOP counts.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- rst=1 mid-stream, then release -> tx=ty=tz=000, busy=0, done=0 within the same cycle as rst rises.
- start, op=001 LDX (DONE_HOLD=0) -> tx=001 and x_src=0 exactly one cycle, two cycles after start; done one cycle later; busy high for 3 cycles.
- start, op=100 SHR, amt=3 -> tx=010 for 3 consecutive cycles, then done; amt=0 -> no SHIFTR cycle, done 2 cycles after start.
- start, op=011 SUB -> ula_op=01 and tz=001 for one cycle, tx/ty=000; then op=110 CLR -> tx=ty=tz=100 for one cycle.
- start held high across SHL amt=2 with op changed mid-instruction -> second instruction accepted only in IDLE after done, using the op present at that edge.
- With REG_CTRL_INSTR_COUNT_EN defined: issue 257 NOPs -> instr_count=1; rst -> 0.

Source files
------------

// File: rtl/reg_control_unit.sv
// ============================================================================
// Module      : reg_control_unit
// Description : Control sequencer for the 4-bit X/Y/Z register file. Accepts
//               one instruction per start/done handshake. Expands it into
//               multi-cycle 3-bit register opcodes, an ULA select and the
//               X load-source select.
// Options     : REG_CTRL_INSTR_COUNT_EN - adds output instr_count [7:0], a
//               wrapping count of completed instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_control_unit #(
  parameter int AMT_W     = 2,
  parameter int DONE_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [2:0]       tx,
  output logic [2:0]       ty,
  output logic [2:0]       tz,
  output logic [1:0]       ula_op,
  output logic             x_src,
  output logic             busy,
  output logic             done
`ifdef REG_CTRL_INSTR_COUNT_EN
  ,
  output logic [7:0]       instr_count
`endif
);

  // Counter must hold both the largest shift amount and the largest DONE_HOLD.
  localparam int CNT_W = (AMT_W > 2) ? AMT_W : 2;

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_HOLD_CNT = CNT_W'(DONE_HOLD);
  localparam logic             C_HAS_HOLD = (DONE_HOLD != 0);

  // Register-file opcodes
  localparam logic [2:0] RO_HOLD   = 3'b000;
  localparam logic [2:0] RO_LOAD   = 3'b001;
  localparam logic [2:0] RO_SHIFTR = 3'b010;
  localparam logic [2:0] RO_SHIFTL = 3'b011;
  localparam logic [2:0] RO_RESET  = 3'b100;

  // Instruction opcodes
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LDX   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SHR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;
  localparam logic [2:0] OP_MOVZX = 3'b111;

  // FSM states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       tx_q, tx_d;
  logic [2:0]       ty_q, ty_d;
  logic [2:0]       tz_q, tz_d;
  logic [1:0]       ula_q, ula_d;
  logic             xsrc_q, xsrc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_shift;
  logic [2:0]       post_state;
  logic [CNT_W-1:0] post_cnt;

  assign is_shift = (op_q == OP_SHR) || (op_q == OP_SHL);

  // Where to go once the work phase is over: the optional hold, or straight to DONE.
  always_comb begin
    post_state = S_DONE;
    post_cnt   = '0;
    if (C_HAS_HOLD) begin
      post_state = S_WAIT;
      post_cnt   = C_HOLD_CNT;
    end
  end

  // Next-state logic: sequencing, operand latching and the cycle counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DECODE;
          op_d    = op;
          amt_d   = amt;
        end
      end
      S_DECODE: begin
        if ((op_q == OP_NOP) || (is_shift && (amt_q == '0))) begin
          state_d = post_state;
          cnt_d   = post_cnt;
        end else begin
          state_d = S_EXEC;
          cnt_d   = is_shift ? CNT_W'(amt_q) : C_ONE;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - C_ONE;
        if (cnt_q <= C_ONE) begin
          state_d = post_state;
          cnt_d   = post_cnt;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - C_ONE;
        if (cnt_q <= C_ONE) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    tx_d   = RO_HOLD;
    ty_d   = RO_HOLD;
    tz_d   = RO_HOLD;
    ula_d  = 2'b00;
    xsrc_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_EXEC) begin
      case (op_q)
        OP_LDX:   tx_d = RO_LOAD;
        OP_ADD:   tz_d = RO_LOAD;
        OP_SUB: begin
          ula_d = 2'b01;
          tz_d  = RO_LOAD;
        end
        OP_SHR:   tx_d = RO_SHIFTR;
        OP_SHL:   tx_d = RO_SHIFTL;
        OP_CLR: begin
          tx_d = RO_RESET;
          ty_d = RO_RESET;
          tz_d = RO_RESET;
        end
        OP_MOVZX: begin
          tx_d   = RO_LOAD;
          xsrc_d = 1'b1;
        end
        default: tx_d = RO_HOLD;
      endcase
    end
  end

  // State, operand and output registers; reset forces HOLD at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      amt_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= RO_HOLD;
      ty_q    <= RO_HOLD;
      tz_q    <= RO_HOLD;
      ula_q   <= 2'b00;
      xsrc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tz_q    <= tz_d;
      ula_q   <= ula_d;
      xsrc_q  <= xsrc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx     = tx_q;
  assign ty     = ty_q;
  assign tz     = tz_q;
  assign ula_op = ula_q;
  assign x_src  = xsrc_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef REG_CTRL_INSTR_COUNT_EN
  logic [7:0] icnt_q;

  // Completed-instruction counter; steps together with the done pulse and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q <= 8'd0;
    end else if (state_d == S_DONE) begin
      icnt_q <= icnt_q + 8'd1;
    end
  end

  assign instr_count = icnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_control_unit.sv
// ============================================================================
// Module      : tb_reg_control_unit
// Description : Randomised scoreboard bench for reg_control_unit. The
//               stimulus side pushes the expected per-cycle output trace of
//               each accepted instruction; a monitor pops and compares on
//               every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_control_unit;

  localparam int AMT_W = 2;
  localparam int DH    = 0;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] SHL  = 3'b011;
  localparam logic [2:0] RST  = 3'b100;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op    = 3'd0;
  logic [AMT_W-1:0] amt   = '0;
  logic [2:0]       tx, ty, tz;
  logic [1:0]       ula_op;
  logic             x_src, busy, done;
`ifdef REG_CTRL_INSTR_COUNT_EN
  logic [7:0]       instr_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_done_model = 0;

  // expected {tx, ty, tz, ula_op, x_src, busy, done} per cycle
  logic [13:0] sb[$];

  always #5 clk = ~clk;

  reg_control_unit #(
    .AMT_W     (AMT_W),
    .DONE_HOLD (DH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .amt    (amt),
    .tx     (tx),
    .ty     (ty),
    .tz     (tz),
    .ula_op (ula_op),
    .x_src  (x_src),
    .busy   (busy),
    .done   (done)
`ifdef REG_CTRL_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  function automatic logic [13:0] mk(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] c, input logic [1:0] u,
                                      input logic xs, input logic bz, input logic dn);
    return {a, b, c, u, xs, bz, dn};
  endfunction

  function automatic logic [13:0] cur();
    return {tx, ty, tz, ula_op, x_src, busy, done};
  endfunction

  // number of cycles the instruction spends actively driving the register file
  function automatic int exec_len(input logic [2:0] o, input logic [AMT_W-1:0] a);
    if (o == 3'd0) return 0;
    if (o == 3'd4 || o == 3'd5) return int'(a);
    return 1;
  endfunction

  // what the register file sees during one active cycle of instruction o
  function automatic logic [13:0] exec_vec(input logic [2:0] o);
    case (o)
      3'd1:    return mk(LOAD, HOLD, HOLD, 2'b00, 1'b0, 1'b1, 1'b0);
      3'd2:    return mk(HOLD, HOLD, LOAD, 2'b00, 1'b0, 1'b1, 1'b0);
      3'd3:    return mk(HOLD, HOLD, LOAD, 2'b01, 1'b0, 1'b1, 1'b0);
      3'd4:    return mk(SHR,  HOLD, HOLD, 2'b00, 1'b0, 1'b1, 1'b0);
      3'd5:    return mk(SHL,  HOLD, HOLD, 2'b00, 1'b0, 1'b1, 1'b0);
      3'd6:    return mk(RST,  RST,  RST,  2'b00, 1'b0, 1'b1, 1'b0);
      default: return mk(LOAD, HOLD, HOLD, 2'b00, 1'b1, 1'b1, 1'b0);
    endcase
  endfunction

  // Trace for the cycles following the accepting edge: decode, active cycles,
  // hold cycles, done, and the idle cycle in which the next start can land.
  task automatic push_trace(input logic [2:0] o, input logic [AMT_W-1:0] a);
    sb.push_back(mk(HOLD, HOLD, HOLD, 2'b00, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < exec_len(o, a); i++) sb.push_back(exec_vec(o));
    for (int i = 0; i < DH; i++) sb.push_back(mk(HOLD, HOLD, HOLD, 2'b00, 1'b0, 1'b1, 1'b0));
    sb.push_back(mk(HOLD, HOLD, HOLD, 2'b00, 1'b0, 1'b1, 1'b1));
    sb.push_back(14'd0);
    n_done_model++;
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
  endtask

  // Issue one instruction while the DUT is idle. mode 0: start low while busy;
  // mode 1: random start/op/amt while busy; mode 2: start held high, op/amt random.
  task automatic issue(input logic [2:0] o, input logic [AMT_W-1:0] a, input int mode);
    int len;
    start = 1'b1;
    op    = o;
    amt   = a;
    @(posedge clk); #1;
    push_trace(o, a);
    len = 3 + exec_len(o, a) + DH;
    for (int k = 0; k < len - 1; k++) begin
      if (mode == 0)      start = 1'b0;
      else if (mode == 1) start = 1'($urandom_range(0, 1));
      else                start = 1'b1;
      if (mode != 0) begin
        op  = 3'($urandom);
        amt = AMT_W'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      op  = 3'($urandom);
      amt = AMT_W'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare every cycle against the scoreboard (idle when it is empty).
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) check("trace", cur(), sb.pop_front());
      else               check("idle", cur(), 14'd0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", cur(), 14'd0);
    rst = 1'b0;
    n_done_model = 0;
    idle(2);

    // directed: LDX, max and zero shifts, SUB then CLR, remaining ops
    issue(3'd1, 2'd0, 0);
    issue(3'd4, 2'd3, 0);
    issue(3'd4, 2'd0, 0);
    issue(3'd3, 2'd1, 1);
    issue(3'd6, 2'd2, 0);
    issue(3'd2, 2'd0, 1);
    issue(3'd7, 2'd0, 0);
    issue(3'd0, 2'd3, 0);
    issue(3'd5, 2'd3, 0);
    // start held high through SHL amt=2; next op chosen at the accepting edge
    issue(3'd5, 2'd2, 2);
    issue(3'd1, 2'd0, 0);
    idle(3);

    // reset in the middle of a 3-cycle shift
    start = 1'b1; op = 3'd4; amt = 2'd3;
    @(posedge clk); #1;
    push_trace(3'd4, 2'd3);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    sb.delete();
    n_done_model = 0;
    #1 check("rst_mid_exec", cur(), 14'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // randomised instructions
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom), AMT_W'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());

`ifdef REG_CTRL_INSTR_COUNT_EN
    check("instr_count", {6'd0, instr_count}, {6'd0, 8'(n_done_model)});
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_done_model = 0;
    for (int i = 0; i < 257; i++) issue(3'd0, AMT_W'($urandom), 0);
    idle(2);
    check("instr_count_257", {6'd0, instr_count}, {6'd0, 8'(n_done_model)});
    #1 rst = 1'b1;
    #1 check("instr_count_rst", {6'd0, instr_count}, 14'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
